// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between N requesters, the write arbiter and the FIFO write port.
// A beat moves on a cycle where req_valid[i] and req_ready[i] are both high; wr_en only pulses on such a cycle.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  // Internal state mirrored out for observation.
  logic                          dbg_state;
  logic [PTR_W-1:0]              dbg_rr_ptr;
  logic [CNT_W-1:0]              dbg_beat_cnt;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr_en, wr_data, grant, busy, dbg_state, dbg_rr_ptr, dbg_beat_cnt
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr_en, wr_data, grant, busy, dbg_state, dbg_rr_ptr, dbg_beat_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time for up to MAX_BURST
// beats into a single FIFO write port, holding the grant through FIFO-full backpressure.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [PTR_W-1:0]     sel_idx;
  logic                 sel_found;
  logic [PTR_W-1:0]     cand_idx;
  int                   cand;
  logic [PTR_W-1:0]     data_idx;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic                 g_valid;
  logic                 wr_en_c;
  logic [NUM_REQ-1:0]   req_ready_c;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_idx   = rr_ptr_q;
    sel_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!sel_found && bus.req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Outside a burst the write port shows requester 0; wr_en is low then anyway.
  always_comb begin
    data_idx  = (state_q == BURST) ? gidx_q : '0;
    wr_data_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (data_idx == PTR_W'(i)) wr_data_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid = bus.req_valid[gidx_q];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    wr_en_c     = 1'b0;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        grant_d    = '0;
        beat_cnt_d = '0;
        if (sel_found) begin
          state_d = BURST;
          gidx_d  = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
        end
      end
      BURST: begin
        req_ready_c[gidx_q] = ~bus.full;
        wr_en_c             = g_valid & ~bus.full;
        // A stalled (full) cycle neither ends the burst nor counts a beat.
        if (!g_valid || (wr_en_c && (beat_cnt_q == LAST_BEAT))) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + PTR_W'(1);
        end else if (wr_en_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.wr_en        = wr_en_c;
  assign bus.wr_data      = wr_data_c;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_rr_ptr   = rr_ptr_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter: cycle-exact grant/handshake checks
// plus a write-data scoreboard fed from the requester side.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] src_word [NR];
  int            rem      [NR];
  int            drv_seq  [NR] = '{default: 0};
  int            exp_seq  [NR] = '{default: 0};
  logic [DW-1:0] exp_q[$];
  logic          rand_mode = 1'b0;
  int            beats_in_grant = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [NR-1:0] rnd_v;
  logic [NR-1:0] rnd_hs;

  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = src_word[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed cycle: drive at posedge+1, check at negedge, advance sources on handshake.
  task automatic cyc(input string tag, input logic f, input logic r,
                     input logic [NR-1:0] eg, input logic ew);
    logic [NR-1:0] hs;
    rst      = r;
    bus.full = f;
    for (int i = 0; i < NR; i++) bus.req_valid[i] = (rem[i] > 0);
    @(negedge clk);
    check($sformatf("%s.grant", tag), 32'(bus.grant), 32'(eg));
    check($sformatf("%s.wr_en", tag), 32'(bus.wr_en), 32'(ew));
    check($sformatf("%s.busy", tag), 32'(bus.busy), 32'(eg != '0));
    check($sformatf("%s.req_ready", tag), 32'(bus.req_ready), 32'(eg & {NR{~f}}));
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        rem[i]--;
        src_word[i]++;
      end
    end
  endtask

  // Write-side monitor: every wr_en must consume one expected word.
  always @(negedge clk) begin : mon
    logic [DW-1:0] got;
    int idx;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) exp_q.push_back(src_word[i]);
    end
    if (bus.grant === '0) beats_in_grant = 0;
    if (bus.wr_en === 1'b1) begin
      beats_in_grant++;
      check("beats_per_grant", 32'(beats_in_grant <= MB), 32'd1);
      check("wr_en_while_full", 32'(bus.full), 32'd0);
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check("wr_data", 32'(bus.wr_data), 32'(got));
      end
      if (rand_mode) begin
        idx = int'(bus.wr_data[7:6]);
        check("rand.order", 32'(bus.wr_data[5:0]), 32'(exp_seq[idx] % 64));
        check("rand.grant", 32'(bus.grant), 32'(1 << idx));
        exp_seq[idx]++;
        check("rand.once", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      src_word[i] = '0;
      rem[i]      = 0;
    end
    bus.req_valid = '0;
    bus.full      = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 1'b0, 1'b1, 4'b0000, 1'b0);
    check("reset.rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
    check("reset.beat_cnt", 32'(bus.dbg_beat_cnt), 32'd0);
    check("reset.state", 32'(bus.dbg_state), 32'd0);

    // Single requester, 6 beats: 4-beat burst, one IDLE, re-grant for the last 2.
    rem[1] = 6; src_word[1] = 8'h10;
    for (int b = 0; b < 6; b++) exp_q.push_back(8'(8'h10 + b));
    cyc("t1.arb", 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int b = 0; b < 4; b++) cyc("t1.burst", 1'b0, 1'b0, 4'b0010, 1'b1);
    cyc("t1.idle", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t1.rr_ptr", 32'(bus.dbg_rr_ptr), 32'd2);
    for (int b = 0; b < 2; b++) cyc("t1.regrant", 1'b0, 1'b0, 4'b0010, 1'b1);
    cyc("t1.drop", 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("t1.empty", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t1.drained", 32'(exp_q.size()), 32'd0);

    // Round robin from rr_ptr=0, one beat per requester, twice round.
    cyc("t2.reset", 1'b0, 1'b1, 4'b0000, 1'b0);
    check("t2.rr_reset", 32'(bus.dbg_rr_ptr), 32'd0);
    for (int i = 0; i < NR; i++) begin
      rem[i] = 1;
      src_word[i] = 8'(8'h40 + 16 * i);
      exp_q.push_back(8'(8'h40 + 16 * i));
    end
    for (int k = 0; k < NR; k++) begin
      cyc("t2.arb", 1'b0, 1'b0, 4'b0000, 1'b0);
      cyc("t2.beat", 1'b0, 1'b0, 4'(1 << k), 1'b1);
      cyc("t2.drop", 1'b0, 1'b0, 4'(1 << k), 1'b0);
    end
    cyc("t2.none", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t2.rr_wrap", 32'(bus.dbg_rr_ptr), 32'd0);
    for (int i = 0; i < NR; i++) begin
      rem[i] = 1;
      exp_q.push_back(8'(8'h41 + 16 * i));
    end
    for (int k = 0; k < NR; k++) begin
      cyc("t2.arb2", 1'b0, 1'b0, 4'b0000, 1'b0);
      cyc("t2.beat2", 1'b0, 1'b0, 4'(1 << k), 1'b1);
      cyc("t2.drop2", 1'b0, 1'b0, 4'(1 << k), 1'b0);
    end
    cyc("t2.none2", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t2.drained", 32'(exp_q.size()), 32'd0);

    // Backpressure on beat 2 of a requester-2 burst.
    cyc("t3.reset", 1'b0, 1'b1, 4'b0000, 1'b0);
    rem[2] = 4; src_word[2] = 8'h20;
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h20 + b));
    cyc("t3.arb", 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("t3.beat0", 1'b0, 1'b0, 4'b0100, 1'b1);
    cyc("t3.beat1", 1'b0, 1'b0, 4'b0100, 1'b1);
    for (int s = 0; s < 3; s++) begin
      cyc("t3.full", 1'b1, 1'b0, 4'b0100, 1'b0);
      check("t3.beat_cnt_held", 32'(bus.dbg_beat_cnt), 32'd2);
    end
    cyc("t3.beat2", 1'b0, 1'b0, 4'b0100, 1'b1);
    cyc("t3.beat3", 1'b0, 1'b0, 4'b0100, 1'b1);
    cyc("t3.idle", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t3.rr_ptr", 32'(bus.dbg_rr_ptr), 32'd3);
    check("t3.drained", 32'(exp_q.size()), 32'd0);

    // Early end: requester 3 offers only 2 beats.
    rem[3] = 2; src_word[3] = 8'h30;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    cyc("t4.arb", 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("t4.beat", 1'b0, 1'b0, 4'b1000, 1'b1);
    cyc("t4.beat", 1'b0, 1'b0, 4'b1000, 1'b1);
    cyc("t4.drop", 1'b0, 1'b0, 4'b1000, 1'b0);
    check("t4.state", 32'(bus.dbg_state), 32'd0);
    check("t4.rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
    cyc("t4.idle", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t4.drained", 32'(exp_q.size()), 32'd0);

    // Reset during beat 1 of requester 2; beats already handshaken stay written.
    rem[2] = 4; src_word[2] = 8'h50;
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    cyc("t5.arb", 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("t5.beat0", 1'b0, 1'b0, 4'b0100, 1'b1);
    cyc("t5.beat1_rst", 1'b0, 1'b1, 4'b0100, 1'b1);
    rem[2] = 0;
    rem[1] = 1; src_word[1] = 8'h61;
    rem[3] = 1; src_word[3] = 8'h63;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h63);
    cyc("t5.after_rst", 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("t5.g1", 1'b0, 1'b0, 4'b0010, 1'b1);
    cyc("t5.g1drop", 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("t5.arb3", 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("t5.g3", 1'b0, 1'b0, 4'b1000, 1'b1);
    cyc("t5.g3drop", 1'b0, 1'b0, 4'b1000, 1'b0);
    cyc("t5.idle", 1'b0, 1'b0, 4'b0000, 1'b0);
    check("t5.drained", 32'(exp_q.size()), 32'd0);

    // Random stress: sticky random valids, random full, sequence-tagged data.
    cyc("t6.reset", 1'b0, 1'b1, 4'b0000, 1'b0);
    rst = 1'b0;
    rand_mode = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      rnd_v = bus.req_valid;
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) == 0) rnd_v[i] = ~rnd_v[i];
        src_word[i] = {2'(i), 6'(drv_seq[i])};
      end
      bus.req_valid = rnd_v;
      bus.full      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      rnd_hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (rnd_hs[i]) drv_seq[i]++;
    end
    bus.req_valid = '0;
    bus.full      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      check($sformatf("t6.count%0d", i), 32'(exp_seq[i]), 32'(drv_seq[i]));
    check("t6.drained", 32'(exp_q.size()), 32'd0);
    check("t6.grant_idle", 32'(bus.grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
